mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 256-bit data-memory port between two cache controllers: m0 (instruction cache) and m1 (data cache).
- Both masters use the same enable/write/addr/data/ack handshake that the caches already drive toward memory. The arbiter sits between the caches and the data memory.
- It serializes whole-line transactions, round-robin or fixed priority, and routes each ack and each read-data return only to the master that owns the transaction.

Parameters:
- ADDR_W, 32, byte-address width (line-aligned, bits [4:0] = 0)
- LINE_W, 256, cache line / memory data width
- RR_EN, 1, 1 = round-robin; 0 = fixed priority with m1 over m0

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- m0_enable_i  in  1  m0 request; held high until m0_ack_o
- m0_write_i  in  1  m0 direction, 1 = write line
- m0_addr_i  in  ADDR_W  m0 line address
- m0_data_i  in  LINE_W  m0 write data
- m0_data_o  out  LINE_W  read data to m0
- m0_ack_o  out  1  transaction complete for m0
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o: same as m0, for m1
- mem_enable_o  out  1  request to data memory
- mem_write_o  out  1  direction to memory
- mem_addr_o  out  ADDR_W  address to memory
- mem_data_o  out  LINE_W  write data to memory
- mem_data_i  in  LINE_W  read data from memory
- mem_ack_i  in  1  memory completion, one cycle
- grant_o  out  2  one-hot current owner {m1,m0}; 00 when idle
- busy_o  out  1  transaction in flight

Behaviour:
- States:
  - IDLE: no owner.
  - BUSY0: m0 owns the memory port.
  - BUSY1: m1 owns the memory port.
- Reset (rst_i high at a clock edge):
  - state = IDLE, last_grant = m1 (so m0 wins the first round-robin tie).
  - All outputs 0: mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, m*_ack_o, m*_data_o, grant_o, busy_o.
  - Reset mid-transaction abandons the transaction with no ack; the memory sees mem_enable_o fall in the cycle after reset.
- IDLE:
  - No requests → stay in IDLE.
  - Exactly one mX_enable_i high → next state BUSYX.
  - Both high:
    - RR_EN=1: grant the master not equal to last_grant.
    - RR_EN=0: grant m1.
  - last_grant is updated on entry to BUSYX.
- BUSYX:
  - mem_enable_o = 1; mem_write_o, mem_addr_o, mem_data_o taken combinationally from mX inputs.
  - grant_o has bit X set; busy_o = 1.
  - The owner's inputs must stay stable until its ack; the arbiter does not latch them.
- Completion:
  - mX_ack_o = mem_ack_i while in BUSYX (same cycle, combinational).
  - The non-owner's ack is always 0.
  - On a clock edge with mem_ack_i high: next state = IDLE.
- Read data:
  - mX_data_o = mem_data_i while in BUSYX, else 0.
  - The owner captures the data in the ack cycle.
- Latency:
  - Request is sampled in IDLE at edge t; mem_enable_o is high from cycle t+1.
  - After an ack, there is one mandatory IDLE cycle with mem_enable_o = 0 (turnaround), so the memory sees a fresh rising enable.
  - Minimum gap between two transactions: 1 cycle.
- Requests during a transaction:
  - A request from the non-owner is ignored until IDLE; it is not lost, since masters hold enable.
- Owner drops enable before ack (protocol violation):
  - The arbiter stays in BUSYX until mem_ack_i.
  - mem_enable_o stays high (it follows state, not mX_enable_i).
- mem_ack_i while IDLE: ignored; no ack is forwarded.
- Starvation:
  - RR_EN=1: with both masters continuously requesting, grants strictly alternate.
  - RR_EN=0: m0 may starve; this is the documented behaviour.

Test Plan:
- Reset: drive rst_i=1 for 2 cycles with m0_enable_i=1 → all outputs 0 and grant_o=00 during reset; mem_enable_o=1 and grant_o=01 one cycle after release.
- Single read: m1 read at addr 0x0000_0420; memory acks 10 cycles later with data 0xA5.. pattern → mem_addr_o=0x0000_0420 and mem_write_o=0; m1_ack_o high exactly in the ack cycle with m1_data_o=pattern; m0_ack_o stays 0; state returns to IDLE after the ack.
- Simultaneous requests, RR_EN=1, both held: m0 write to 0x100 and m1 read from 0x200 → order m0, m1, m0, m1; each transaction separated by exactly one cycle with mem_enable_o=0.
- Simultaneous requests, RR_EN=0 → m1 granted first; m0 granted only after m1 drops enable.
- Write-back followed by refill from m1 (write to 0x3C0, then read from 0x7C0): data 0xDEAD.. appears on mem_data_o during the write; the read is issued after the 1-cycle turnaround.
- Stray mem_ack_i pulse while IDLE → no mX_ack_o and no state change; reset asserted mid-BUSY1 → the transaction is abandoned with no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared 256-bit data-memory port.
// Serializes whole-line transactions and routes ack/read data back to the owner only.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned LINE_W = 256,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_enable_i,
   input  logic              m0_write_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [LINE_W-1:0] m0_data_i,
   output logic [LINE_W-1:0] m0_data_o,
   output logic              m0_ack_o,
   input  logic              m1_enable_i,
   input  logic              m1_write_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [LINE_W-1:0] m1_data_i,
   output logic [LINE_W-1:0] m1_data_o,
   output logic              m1_ack_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [1:0]        grant_o,
   output logic              busy_o
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

   state_t state;
   logic   last_grant;   // 1 = m1 was granted last
   logic   pick_m1_c;
   logic   own0_c;
   logic   own1_c;

   // Winner selection when sampling requests in IDLE
   always_comb begin
      pick_m1_c = 1'b0;
      if (m0_enable_i && m1_enable_i)
         pick_m1_c = RR_EN ? ~last_grant : 1'b1;
      else
         pick_m1_c = m1_enable_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         grant_o      <= 2'b00;
         busy_o       <= 1'b0;
         mem_enable_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_enable_i || m1_enable_i) begin
                  busy_o       <= 1'b1;
                  mem_enable_o <= 1'b1;
                  last_grant   <= pick_m1_c;
                  if (pick_m1_c) begin
                     state   <= BUSY1;
                     grant_o <= 2'b10;
                  end else begin
                     state   <= BUSY0;
                     grant_o <= 2'b01;
                  end
               end
            end
            BUSY0, BUSY1: begin
               // Completion always passes through IDLE so memory sees a fresh enable edge
               if (mem_ack_i) begin
                  state        <= IDLE;
                  grant_o      <= 2'b00;
                  busy_o       <= 1'b0;
                  mem_enable_o <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               grant_o      <= 2'b00;
               busy_o       <= 1'b0;
               mem_enable_o <= 1'b0;
            end
         endcase
      end
   end

   assign own0_c = (state == BUSY0);
   assign own1_c = (state == BUSY1);

   // Request fields pass straight through from the owner; the owner holds them stable
   assign mem_write_o = (own0_c & m0_write_i) | (own1_c & m1_write_i);
   assign mem_addr_o  = own0_c ? m0_addr_i : (own1_c ? m1_addr_i : '0);
   assign mem_data_o  = own0_c ? m0_data_i : (own1_c ? m1_data_i : '0);

   assign m0_ack_o  = own0_c & mem_ack_i;
   assign m1_ack_o  = own1_c & mem_ack_i;
   assign m0_data_o = own0_c ? mem_data_i : '0;
   assign m1_data_o = own1_c ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps plus random traffic checked against an
// ownership-level model of the arbitration rules.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 256;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
   logic [AW-1:0] m0_addr_i, m1_addr_i;
   logic [LW-1:0] m0_data_i, m1_data_i, mem_data_i;
   logic          mem_ack_i;
   logic [LW-1:0] m0_data_o, m1_data_o, mem_data_o;
   logic          m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, busy_o;
   logic [AW-1:0] mem_addr_o;
   logic [1:0]    grant_o;

   // Fixed-priority instance has its own enables and memory ack
   logic          f_m0_en, f_m1_en, f_ack;
   logic [LW-1:0] f_m0_data, f_m1_data, f_mem_data;
   logic          f_m0_ack, f_m1_ack, f_mem_en, f_mem_wr, f_busy;
   logic [AW-1:0] f_mem_addr;
   logic [1:0]    f_grant;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Model: owner 0 = none, 1 = m0, 2 = m1
   int   owner = 0;
   bit   last_m1 = 1'b1;
   int   wait_cnt = 0;
   bit   acked0 = 1'b0, acked1 = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b1)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
      .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .grant_o(grant_o), .busy_o(busy_o)
   );

   mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b0)) dut_fp (
      .clk_i(clk), .rst_i(rst_i),
      .m0_enable_i(f_m0_en), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
      .m0_data_i(m0_data_i), .m0_data_o(f_m0_data), .m0_ack_o(f_m0_ack),
      .m1_enable_i(f_m1_en), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
      .m1_data_i(m1_data_i), .m1_data_o(f_m1_data), .m1_ack_o(f_m1_ack),
      .mem_enable_o(f_mem_en), .mem_write_o(f_mem_wr), .mem_addr_o(f_mem_addr),
      .mem_data_o(f_mem_data), .mem_data_i(mem_data_i), .mem_ack_i(f_ack),
      .grant_o(f_grant), .busy_o(f_busy)
   );

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      logic [31:0] r;
      r = $urandom();
      return r & 32'hFFFF_FFE0;
   endfunction

   // Compare every output with what the current owner implies
   task automatic check_outputs();
      logic [1:0]    eg;
      logic [AW-1:0] ea;
      logic [LW-1:0] ed;
      logic          ew;
      eg = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
      ea = (owner == 1) ? m0_addr_i : (owner == 2) ? m1_addr_i : '0;
      ed = (owner == 1) ? m0_data_i : (owner == 2) ? m1_data_i : '0;
      ew = (owner == 1) ? m0_write_i : (owner == 2) ? m1_write_i : 1'b0;
      chk("grant", LW'(grant_o), LW'(eg));
      chk("busy", LW'(busy_o), LW'(owner != 0));
      chk("mem_enable", LW'(mem_enable_o), LW'(owner != 0));
      chk("mem_write", LW'(mem_write_o), LW'(ew));
      chk("mem_addr", LW'(mem_addr_o), LW'(ea));
      chk("mem_wdata", mem_data_o, ed);
      chk("m0_ack", LW'(m0_ack_o), LW'(owner == 1 && mem_ack_i));
      chk("m1_ack", LW'(m1_ack_o), LW'(owner == 2 && mem_ack_i));
      chk("m0_rdata", m0_data_o, (owner == 1) ? mem_data_i : '0);
      chk("m1_rdata", m1_data_o, (owner == 2) ? mem_data_i : '0);
   endtask

   // Ownership rules applied at each rising edge
   task automatic update_model();
      if (rst_i) begin
         owner   = 0;
         last_m1 = 1'b1;
      end else if (owner != 0) begin
         if (mem_ack_i) begin
            if (owner == 1) acked0 = 1'b1; else acked1 = 1'b1;
            owner = 0;
         end
      end else if (m0_enable_i || m1_enable_i) begin
         if (m0_enable_i && m1_enable_i) owner = last_m1 ? 1 : 2;
         else owner = m0_enable_i ? 1 : 2;
         last_m1  = (owner == 2);
         wait_cnt = $urandom_range(0, 3);
      end
   endtask

   task automatic cycle();
      #1 check_outputs();
      @(posedge clk);
      update_model();
      @(negedge clk);
   endtask

   task automatic fp_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [LW-1:0] pat;
      rst_i = 1'b1; mem_ack_i = 1'b0; mem_data_i = '0;
      m0_enable_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h0000_0040; m0_data_i = '0;
      m1_enable_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
      f_m0_en = 1'b0; f_m1_en = 1'b0; f_ack = 1'b0;

      // Reset held two cycles with m0 requesting
      @(posedge clk); update_model(); @(negedge clk);
      cycle();
      rst_i = 1'b0;
      cycle();
      chk("rst_release_grant", LW'(grant_o), LW'(2'b01));
      chk("rst_release_en", LW'(mem_enable_o), LW'(1'b1));
      mem_ack_i = 1'b1; mem_data_i = rand_line();
      cycle();
      m0_enable_i = 1'b0; mem_ack_i = 1'b0;
      cycle();

      // Single m1 read with a 10-cycle memory latency
      pat = {32{8'hA5}};
      m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h0000_0420;
      cycle();
      chk("rd_addr", LW'(mem_addr_o), LW'(32'h0000_0420));
      chk("rd_write", LW'(mem_write_o), LW'(1'b0));
      repeat (9) cycle();
      mem_ack_i = 1'b1; mem_data_i = pat;
      #1;
      chk("rd_ack", LW'(m1_ack_o), LW'(1'b1));
      chk("rd_data", m1_data_o, pat);
      chk("rd_m0_ack", LW'(m0_ack_o), LW'(1'b0));
      cycle();
      chk("rd_idle", LW'(grant_o), LW'(2'b00));
      m1_enable_i = 1'b0; mem_ack_i = 1'b0;
      cycle();

      // Both held under round-robin: m0, m1, m0, m1 with one idle cycle between
      m0_enable_i = 1'b1; m0_write_i = 1'b1; m0_addr_i = 32'h100; m0_data_i = rand_line();
      m1_enable_i = 1'b1; m1_write_i = 1'b0; m1_addr_i = 32'h200;
      cycle();
      for (int k = 0; k < 4; k++) begin
         chk("rr_order", LW'(grant_o), (k % 2 == 1) ? LW'(2'b10) : LW'(2'b01));
         cycle();
         mem_ack_i = 1'b1; mem_data_i = rand_line();
         cycle();
         mem_ack_i = 1'b0;
         if (k == 3) begin m0_enable_i = 1'b0; m1_enable_i = 1'b0; end
         chk("rr_turnaround", LW'(mem_enable_o), LW'(1'b0));
         cycle();
      end

      // m1 write-back then refill
      pat = {8{32'hDEAD_BEEF}};
      m1_enable_i = 1'b1; m1_write_i = 1'b1; m1_addr_i = 32'h3C0; m1_data_i = pat;
      cycle();
      chk("wb_data", mem_data_o, pat);
      chk("wb_write", LW'(mem_write_o), LW'(1'b1));
      mem_ack_i = 1'b1;
      cycle();
      m1_write_i = 1'b0; m1_addr_i = 32'h7C0; mem_ack_i = 1'b0;
      chk("wb_turnaround", LW'(mem_enable_o), LW'(1'b0));
      cycle();
      chk("refill_addr", LW'(mem_addr_o), LW'(32'h7C0));
      chk("refill_en", LW'(mem_enable_o), LW'(1'b1));
      mem_ack_i = 1'b1;
      cycle();
      m1_enable_i = 1'b0; mem_ack_i = 1'b0;
      cycle();

      // Stray ack while idle
      mem_ack_i = 1'b1;
      cycle();
      mem_ack_i = 1'b0;
      chk("stray_grant", LW'(grant_o), LW'(2'b00));
      chk("stray_busy", LW'(busy_o), LW'(1'b0));

      // Reset in the middle of an m1 transaction
      m1_enable_i = 1'b1; m1_addr_i = 32'h0000_0AE0;
      cycle();
      cycle();
      rst_i = 1'b1;
      cycle();
      chk("rst_abandon_en", LW'(mem_enable_o), LW'(1'b0));
      chk("rst_abandon_ack", LW'(m1_ack_o), LW'(1'b0));
      rst_i = 1'b0; m1_enable_i = 1'b0;
      cycle();

      // Random traffic
      acked0 = 1'b0; acked1 = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (acked0) begin m0_enable_i = 1'b0; acked0 = 1'b0; end
         else if (!m0_enable_i && ($urandom() % 4 == 0)) begin
            m0_enable_i = 1'b1; m0_write_i = 1'($urandom() % 2);
            m0_addr_i = rand_addr(); m0_data_i = rand_line();
         end
         if (acked1) begin m1_enable_i = 1'b0; acked1 = 1'b0; end
         else if (!m1_enable_i && ($urandom() % 4 == 0)) begin
            m1_enable_i = 1'b1; m1_write_i = 1'($urandom() % 2);
            m1_addr_i = rand_addr(); m1_data_i = rand_line();
         end
         mem_data_i = rand_line();
         if (owner != 0) begin
            if (wait_cnt == 0) mem_ack_i = 1'b1;
            else begin mem_ack_i = 1'b0; wait_cnt--; end
         end else begin
            mem_ack_i = ($urandom() % 8 == 0);
         end
         cycle();
      end
      m0_enable_i = 1'b0; m1_enable_i = 1'b0; mem_ack_i = 1'b0;

      // Fixed priority: m1 keeps winning until it releases enable
      f_m0_en = 1'b1; f_m1_en = 1'b1;
      fp_cycle();
      chk("fp_first", LW'(f_grant), LW'(2'b10));
      f_ack = 1'b1;
      #1;
      chk("fp_m1_ack", LW'(f_m1_ack), LW'(1'b1));
      chk("fp_m0_ack", LW'(f_m0_ack), LW'(1'b0));
      fp_cycle();
      f_ack = 1'b0;
      chk("fp_turn1", LW'(f_grant), LW'(2'b00));
      fp_cycle();
      chk("fp_m1_again", LW'(f_grant), LW'(2'b10));
      f_ack = 1'b1;
      fp_cycle();
      f_ack = 1'b0; f_m1_en = 1'b0;
      chk("fp_turn2", LW'(f_mem_en), LW'(1'b0));
      fp_cycle();
      chk("fp_m0_granted", LW'(f_grant), LW'(2'b01));
      f_ack = 1'b1;
      #1;
      chk("fp_m0_done", LW'(f_m0_ack), LW'(1'b1));
      fp_cycle();
      f_ack = 1'b0; f_m0_en = 1'b0;
      fp_cycle();
      chk("fp_idle", LW'(f_busy), LW'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
